// File: rtl/cim_tile_model.sv
`timescale 1ns/1ps
// cim_tile_model
//   Responder side of one CIM crossbar tile. The layer loads input rows and
//   weights, pulses i_start, and the tile multiplies row by row (one row per
//   cycle). It then waits out the ADC latency and publishes quantized column
//   results into a register file. The layer reads that file back by address.
//
// Build option:
//   CIM_TILE_SAT_EN  - quantization saturates to all ones on overflow.
//                      When it is not defined, quantization keeps the low
//                      datatype_size bits (wrap-around).
//
// Ports:
//   clk, rst        clock (rising edge), async active-low reset
//   i_wr_en/addr/data   input-row buffer write (honoured only when idle)
//   i_start         single-cycle MVM start (honoured only when idle)
//   o_busy          MVM in progress
//   o_done          one-cycle pulse when results are published
//   i_rd_addr       result word index; o_rd_data is registered (latency 1)
//   i_w_we/row/col/data weight programming (honoured only when idle)
//
// Assumes n_out is a power of two and at least 2.
module cim_tile_model #(
    parameter int xbar_size     = 128,
    parameter int datatype_size = 4,
    parameter int n_out         = xbar_size / datatype_size,
    parameter int adc_latency   = 4,
    parameter int out_shift     = 7,
    parameter int acc_size      = 2 * datatype_size + $clog2(xbar_size)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr_en,
    input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
    input  logic [datatype_size-1:0]     i_wr_data,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
    output logic [datatype_size-1:0]     o_rd_data,
    input  logic                         i_w_we,
    input  logic [$clog2(xbar_size)-1:0] i_w_row,
    input  logic [$clog2(n_out)-1:0]     i_w_col,
    input  logic [datatype_size-1:0]     i_w_data
);

    localparam int AW   = $clog2(xbar_size);
    localparam int CW   = $clog2(n_out);
    localparam int DW   = datatype_size;
    localparam int CNTW = $clog2(adc_latency + 1);

    localparam logic [AW-1:0]       NOUT_A   = AW'(n_out);
    localparam logic [AW-1:0]       LAST_ROW = AW'(xbar_size - 1);
    localparam logic [acc_size-1:0] QMAX     = acc_size'((1 << DW) - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_ADC  = 2'd2;

    logic [1:0]                              r_state;
    logic [AW-1:0]                           r_row;
    logic [CNTW-1:0]                         r_adc_cnt;
    logic [xbar_size-1:0][DW-1:0]            r_in_buf;
    logic [xbar_size-1:0][n_out-1:0][DW-1:0] r_w;
    logic [n_out-1:0][acc_size-1:0]          r_acc;
    logic [n_out-1:0][DW-1:0]                r_res;
    logic                                    r_done;
    logic [DW-1:0]                           r_rd_data;

    logic                       w_idle;
    logic [n_out-1:0][2*DW-1:0] w_prod;

    assign w_idle    = (r_state == S_IDLE);
    assign o_busy    = !w_idle;
    assign o_done    = r_done;
    assign o_rd_data = r_rd_data;

    function automatic logic [DW-1:0] quant(input logic [acc_size-1:0] a);
        logic [acc_size-1:0] s;
        s = a >> out_shift;
`ifdef CIM_TILE_SAT_EN
        if (s > QMAX) return '1;
        return s[DW-1:0];
`else
        return s[DW-1:0];
`endif
    endfunction

    // Operands are widened first, so the product is a full 2*DW bits.
    always_comb begin
        w_prod = '0;
        for (int c = 0; c < n_out; c++)
            w_prod[c] = {{DW{1'b0}}, r_in_buf[r_row]} * {{DW{1'b0}}, r_w[r_row][c]};
    end

    // Weights are deliberately not reset; they persist across resets.
    always_ff @(posedge clk) begin
        if (w_idle && i_w_we) r_w[i_w_row][i_w_col] <= i_w_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_adc_cnt <= '0;
            r_in_buf  <= '0;
            r_acc     <= '0;
            r_res     <= '0;
            r_done    <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_done    <= 1'b0;
            // Reads stay live in every state and see res as it was at the edge.
            r_rd_data <= (i_rd_addr < NOUT_A) ? r_res[i_rd_addr[CW-1:0]] : '0;
            case (r_state)
                S_IDLE: begin
                    // A write in the same cycle as start lands before row 0 is read.
                    if (i_wr_en) r_in_buf[i_wr_addr] <= i_wr_data;
                    if (i_start) begin
                        r_acc   <= '0;
                        r_row   <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    for (int c = 0; c < n_out; c++)
                        r_acc[c] <= r_acc[c] + acc_size'(w_prod[c]);
                    r_row <= r_row + 1'b1;
                    if (r_row == LAST_ROW) begin
                        r_adc_cnt <= CNTW'(adc_latency - 1);
                        r_state   <= S_ADC;
                    end
                end
                S_ADC: begin
                    if (r_adc_cnt == '0) begin
                        for (int c = 0; c < n_out; c++)
                            r_res[c] <= quant(r_acc[c]);
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_adc_cnt <= r_adc_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_tile_model.sv
`timescale 1ns/1ps
module tb_cim_tile_model;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_wr_en;
    logic [2:0] i_wr_addr;
    logic [3:0] i_wr_data;
    logic       i_start;
    logic       o_busy;
    logic       o_done;
    logic [2:0] i_rd_addr;
    logic [3:0] o_rd_data;
    logic       i_w_we;
    logic [2:0] i_w_row;
    logic [0:0] i_w_col;
    logic [3:0] i_w_data;

    int tests = 0;
    int fails = 0;

`ifdef CIM_TILE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    cim_tile_model #(
        .xbar_size(8), .datatype_size(4), .n_out(2),
        .adc_latency(4), .out_shift(0), .acc_size(11)
    ) dut (
        .clk(clk), .rst(rst),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
        .i_w_we(i_w_we), .i_w_row(i_w_row), .i_w_col(i_w_col), .i_w_data(i_w_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr_in(input int r, input int v);
        i_wr_en = 1'b1; i_wr_addr = 3'(r); i_wr_data = 4'(v);
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic wr_w(input int r, input int c, input int v);
        i_w_we = 1'b1; i_w_row = 3'(r); i_w_col = 1'(c); i_w_data = 4'(v);
        tick();
        i_w_we = 1'b0;
    endtask

    task automatic rd(input string tag, input int a, input int exp);
        i_rd_addr = 3'(a);
        tick();
        check(tag, 32'(o_rd_data), exp);
    endtask

    // Pulses start (plus any write the caller set up) and counts edges to done.
    task automatic go(input string tag);
        int n;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_wr_en = 1'b0;
        n = 0;
        while (!o_done && n < 30) begin
            tick();
            n++;
        end
        check(tag, n, 12);
    endtask

    initial begin
        int n;
        bit seen_done;
        rst = 1'b0; i_wr_en = 0; i_wr_addr = 0; i_wr_data = 0; i_start = 0;
        i_rd_addr = 0; i_w_we = 0; i_w_row = 0; i_w_col = 0; i_w_data = 0;
        tick(); tick();
        check("reset_busy", 32'(o_busy), 0);
        check("reset_done", 32'(o_done), 0);
        check("reset_rd", 32'(o_rd_data), 0);
        rst = 1'b1;
        tick();

        // Identity MVM, with a write and a second start injected at edge 5.
        for (int r = 0; r < 8; r++) begin
            wr_w(r, 0, 1);
            wr_w(r, 1, 0);
            wr_in(r, 1);
        end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 4) begin
                i_wr_en = 1'b1; i_wr_addr = 3'd0; i_wr_data = 4'd7; i_start = 1'b1;
            end
            if (e == 5) begin
                i_wr_en = 1'b0; i_start = 1'b0;
            end
            if (e == 1)  check("busy_e1", 32'(o_busy), 1);
            if (e == 11) check("busy_e11", 32'(o_busy), 1);
            if (e == 11) check("done_e11", 32'(o_done), 0);
            if (e == 12) check("done_e12", 32'(o_done), 1);
            if (e == 12) check("idle_e12", 32'(o_busy), 0);
            if (e == 13) check("done_e13", 32'(o_done), 0);
        end
        rd("ident_a0", 0, 8);
        rd("ident_a1", 1, 0);

        // Second run with no writes: in_buf[0] must still be 1 (sum 8, not 14).
        go("run2_lat");
        rd("run2_a0", 0, 8);

        // Stale read mid-run, then the new (overflowing) result.
        for (int r = 0; r < 8; r++) wr_in(r, 2);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_rd_addr = 3'd0;
        tick();
        check("stale_rd", 32'(o_rd_data), 8);
        n = 0;
        while (!o_done && n < 30) begin
            tick();
            n++;
        end
        check("run3_done", 32'(o_done), 1);
        rd("run3_a0", 0, SAT ? 15 : 0);

        // Overflow: col0 = 120, col1 = 1800.
        for (int r = 0; r < 8; r++) begin
            wr_in(r, 15);
            wr_w(r, 1, 15);
        end
        go("ovf_lat");
        rd("ovf_a0", 0, SAT ? 15 : 8);
        rd("ovf_a1", 1, SAT ? 15 : 8);
        rd("oor_a2", 2, 0);
        rd("oor_a7", 7, 0);

        // Reset mid-MAC.
        i_rd_addr = 3'd1;
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick(); tick(); tick();
        @(posedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_busy", 32'(o_busy), 0);
        check("rstmid_rd", 32'(o_rd_data), 0);
        check("rstmid_done", 32'(o_done), 0);
        seen_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (o_done) seen_done = 1'b1;
        end
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_done) seen_done = 1'b1;
        end
        check("rstmid_nodone", 32'(seen_done), 0);
        rd("rstmid_a0", 0, 0);
        rd("rstmid_a1", 1, 0);

        // Same-cycle write + start; in_buf is zero after reset, col1 weights stay 15.
        for (int r = 0; r < 7; r++) wr_w(r, 0, 0);
        wr_w(7, 0, 1);
        i_wr_en = 1'b1; i_wr_addr = 3'd7; i_wr_data = 4'd3;
        go("same_lat");
        rd("same_a0", 0, 3);
        rd("same_a1", 1, SAT ? 15 : 13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
